// File: rtl/seq_code_lock_pkg.sv
// Shared types and helpers for the sequential keypad lock.
// Default parameter values and the counter widths derived from them live here.
package seq_code_lock_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2,
        ST_PROG     = 2'd3
    } state_e;

    localparam int unsigned DEF_NUM_DIGITS  = 4;
    localparam int unsigned DEF_KEY_W       = 10;
    localparam int unsigned DEF_MAX_TRIES   = 3;
    localparam int unsigned DEF_UNLOCK_CYC  = 8;
    localparam int unsigned DEF_LOCKOUT_CYC = 16;

    localparam int unsigned DEF_DCNT_W = $clog2(DEF_NUM_DIGITS + 1);
    localparam int unsigned DEF_FCNT_W = $clog2(DEF_MAX_TRIES + 1);

    // Width able to hold values 0..max(a,b)-1, never narrower than one bit.
    function automatic int unsigned timer_w(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

    // Keys wider than 64 bits are not supported by this helper.
    function automatic logic is_onehot(input logic [63:0] k);
        return (k != 64'd0) && ((k & (k - 64'd1)) == 64'd0);
    endfunction

endpackage

// File: rtl/seq_code_lock_timer.sv
// Loadable down-counter shared by the unlock window and the alarm lockout.
// done is high while the count sits at zero.
module lock_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise decrement toward zero while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/seq_code_lock.sv
// Sequential one-hot keypad lock with timed unlock window and failure lockout.
// Optional in-field code programming is enabled by defining CODE_PROG_EN.
module seq_code_lock
    import seq_code_lock_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = DEF_NUM_DIGITS,
    parameter int unsigned KEY_W       = DEF_KEY_W,
    parameter int unsigned MAX_TRIES   = DEF_MAX_TRIES,
    parameter int unsigned UNLOCK_CYC  = DEF_UNLOCK_CYC,
    parameter int unsigned LOCKOUT_CYC = DEF_LOCKOUT_CYC,
    parameter logic [NUM_DIGITS*KEY_W-1:0] RESET_CODE = {10'd2, 10'd8, 10'd512, 10'd1}
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               key_valid,
    input  logic [KEY_W-1:0]                   key,
    input  logic                               clear,
    input  logic [NUM_DIGITS*KEY_W-1:0]        code_i,
    input  logic                               prog,
    output logic                               unlocked,
    output logic                               alarm,
    output logic                               key_err,
    output logic [$clog2(NUM_DIGITS+1)-1:0]    digit_cnt,
    output logic [$clog2(MAX_TRIES+1)-1:0]     fail_cnt
);

    localparam int unsigned DCNT_W  = $clog2(NUM_DIGITS + 1);
    localparam int unsigned FCNT_W  = $clog2(MAX_TRIES + 1);
    localparam int unsigned TIMER_W = timer_w(UNLOCK_CYC, LOCKOUT_CYC);
    localparam int unsigned CODE_W  = NUM_DIGITS * KEY_W;

    state_e              state_q, state_d;
    logic                unlocked_q, unlocked_d;
    logic                alarm_q, alarm_d;
    logic                key_err_q, key_err_d;
    logic                mis_q, mis_d;
    logic [DCNT_W-1:0]   digit_cnt_q, digit_cnt_d;
    logic [FCNT_W-1:0]   fail_cnt_q, fail_cnt_d;

    logic [CODE_W-1:0]   code_s;
    logic [CODE_W-1:0]   code_shift_s;
    logic [KEY_W-1:0]    exp_digit_s;
    logic                key_ok_s;
    logic                digit_bad_s;
    logic                last_digit_s;
    logic [FCNT_W-1:0]   fail_inc_s;
    logic                timer_load_s;
    logic [TIMER_W-1:0]  timer_val_s;
    logic                timer_en_s;
    logic                timer_done_s;

`ifdef CODE_PROG_EN
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CODE_W-1:0]   new_code_q, new_code_d;
    logic [CODE_W-1:0]   digit_mask_s;
    logic                unused_code_s;

    assign code_s        = code_q;
    assign unused_code_s = ^code_i;
    assign digit_mask_s  = CODE_W'({KEY_W{1'b1}}) << (KEY_W * int'(digit_cnt_q));
`else
    logic                unused_prog_s;

    assign code_s        = code_i;
    assign unused_prog_s = prog;
`endif

    assign code_shift_s = code_s >> (KEY_W * int'(digit_cnt_q));
    assign exp_digit_s  = code_shift_s[KEY_W-1:0];
    assign key_ok_s     = is_onehot(64'(key));
    assign digit_bad_s  = !key_ok_s || (key != exp_digit_s);
    assign last_digit_s = (digit_cnt_q == DCNT_W'(NUM_DIGITS - 1));
    assign fail_inc_s   = fail_cnt_q + FCNT_W'(1);
    assign timer_en_s   = (state_q == ST_UNLOCKED) || (state_q == ST_LOCKOUT);

    lock_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load_s),
        .value (timer_val_s),
        .en    (timer_en_s),
        .done  (timer_done_s)
    );

    // Next-state and next-output logic for the lock controller.
    always_comb begin
        state_d      = state_q;
        unlocked_d   = unlocked_q;
        alarm_d      = alarm_q;
        key_err_d    = 1'b0;
        mis_d        = mis_q;
        digit_cnt_d  = digit_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        timer_load_s = 1'b0;
        timer_val_s  = '0;
`ifdef CODE_PROG_EN
        code_d       = code_q;
        new_code_d   = new_code_q;
`endif
        case (state_q)
            ST_ENTRY: begin
                if (clear) begin
                    digit_cnt_d = '0;
                    mis_d       = 1'b0;
                end else if (key_valid) begin
                    key_err_d = !key_ok_s;
                    if (last_digit_s) begin
                        digit_cnt_d = '0;
                        mis_d       = 1'b0;
                        if (!(mis_q || digit_bad_s)) begin
                            state_d      = ST_UNLOCKED;
                            unlocked_d   = 1'b1;
                            fail_cnt_d   = '0;
                            timer_load_s = 1'b1;
                            timer_val_s  = TIMER_W'(UNLOCK_CYC - 1);
                        end else if (fail_inc_s == FCNT_W'(MAX_TRIES)) begin
                            state_d      = ST_LOCKOUT;
                            alarm_d      = 1'b1;
                            fail_cnt_d   = fail_inc_s;
                            timer_load_s = 1'b1;
                            timer_val_s  = TIMER_W'(LOCKOUT_CYC - 1);
                        end else begin
                            fail_cnt_d = fail_inc_s;
                        end
                    end else begin
                        digit_cnt_d = digit_cnt_q + DCNT_W'(1);
                        mis_d       = mis_q | digit_bad_s;
                    end
                end else begin
                    digit_cnt_d = digit_cnt_q;
                end
            end
            ST_UNLOCKED: begin
`ifdef CODE_PROG_EN
                if (prog) begin
                    state_d     = ST_PROG;
                    unlocked_d  = 1'b0;
                    digit_cnt_d = '0;
                    new_code_d  = code_q;
                end else if (timer_done_s) begin
                    state_d    = ST_ENTRY;
                    unlocked_d = 1'b0;
                end else begin
                    state_d = ST_UNLOCKED;
                end
`else
                if (timer_done_s) begin
                    state_d    = ST_ENTRY;
                    unlocked_d = 1'b0;
                end else begin
                    state_d = ST_UNLOCKED;
                end
`endif
            end
            ST_LOCKOUT: begin
                if (timer_done_s) begin
                    state_d    = ST_ENTRY;
                    alarm_d    = 1'b0;
                    fail_cnt_d = '0;
                end else begin
                    state_d = ST_LOCKOUT;
                end
            end
`ifdef CODE_PROG_EN
            ST_PROG: begin
                if (clear) begin
                    state_d     = ST_ENTRY;
                    digit_cnt_d = '0;
                end else if (key_valid && !key_ok_s) begin
                    key_err_d = 1'b1;
                end else if (key_valid) begin
                    // The digit being stored may be the last one, so the full code is built here.
                    new_code_d = (new_code_q & ~digit_mask_s)
                               | (CODE_W'(key) << (KEY_W * int'(digit_cnt_q)));
                    if (last_digit_s) begin
                        code_d      = new_code_d;
                        state_d     = ST_ENTRY;
                        digit_cnt_d = '0;
                    end else begin
                        digit_cnt_d = digit_cnt_q + DCNT_W'(1);
                    end
                end else begin
                    state_d = ST_PROG;
                end
            end
`endif
            default: begin
                state_d     = ST_ENTRY;
                unlocked_d  = 1'b0;
                alarm_d     = 1'b0;
                mis_d       = 1'b0;
                digit_cnt_d = '0;
                fail_cnt_d  = '0;
            end
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ENTRY;
            unlocked_q  <= 1'b0;
            alarm_q     <= 1'b0;
            key_err_q   <= 1'b0;
            mis_q       <= 1'b0;
            digit_cnt_q <= '0;
            fail_cnt_q  <= '0;
`ifdef CODE_PROG_EN
            code_q      <= RESET_CODE;
            new_code_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            unlocked_q  <= unlocked_d;
            alarm_q     <= alarm_d;
            key_err_q   <= key_err_d;
            mis_q       <= mis_d;
            digit_cnt_q <= digit_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
`ifdef CODE_PROG_EN
            code_q      <= code_d;
            new_code_q  <= new_code_d;
`endif
        end
    end

    assign unlocked  = unlocked_q;
    assign alarm     = alarm_q;
    assign key_err   = key_err_q;
    assign digit_cnt = digit_cnt_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_seq_code_lock.sv
// Directed self-checking bench for seq_code_lock (default parameters).
// The programming steps run only when CODE_PROG_EN is defined.
module tb_seq_code_lock;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [9:0]  key;
    logic        clear;
    logic [39:0] code_i;
    logic        prog;
    logic        unlocked;
    logic        alarm;
    logic        key_err;
    logic [2:0]  digit_cnt;
    logic [1:0]  fail_cnt;

    int checks   = 0;
    int failures = 0;

    seq_code_lock dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key       (key),
        .clear     (clear),
        .code_i    (code_i),
        .prog      (prog),
        .unlocked  (unlocked),
        .alarm     (alarm),
        .key_err   (key_err),
        .digit_cnt (digit_cnt),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs updated.
    task automatic press(input logic [9:0] k);
        key_valid = 1'b1;
        key       = k;
        @(negedge clk);
        key_valid = 1'b0;
        key       = 10'd0;
    endtask

    task automatic enter4(input logic [9:0] a, input logic [9:0] b,
                          input logic [9:0] c, input logic [9:0] d);
        press(a);
        press(b);
        press(c);
        press(d);
    endtask

    task automatic count_unlocked(output int n);
        n = 0;
        while (unlocked && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n;
    bit err_seen;
    bit unl_seen;

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key       = 10'd0;
        clear     = 1'b0;
        prog      = 1'b0;
        code_i    = {10'd2, 10'd8, 10'd512, 10'd1};
        #12;
        check("rst_unlocked", unlocked, 0);
        check("rst_alarm", alarm, 0);
        check("rst_key_err", key_err, 0);
        check("rst_digit_cnt", digit_cnt, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Correct code opens one cycle after the last strobe for 8 cycles.
        press(10'd1);
        check("ok_digit1", digit_cnt, 1);
        press(10'd512);
        press(10'd8);
        check("ok_digit3", digit_cnt, 3);
        press(10'd2);
        check("ok_unlocked", unlocked, 1);
        check("ok_digit_wrap", digit_cnt, 0);
        check("ok_fail_cnt", fail_cnt, 0);
        count_unlocked(n);
        check("ok_unlock_len", n, 8);
        check("ok_relocked", unlocked, 0);

        // Three wrong entries trigger a 16-cycle lockout that ignores keys.
        enter4(10'd256, 10'd256, 10'd1, 10'd8);
        check("bad1_unlocked", unlocked, 0);
        check("bad1_fail_cnt", fail_cnt, 1);
        check("bad1_digit_cnt", digit_cnt, 0);
        enter4(10'd256, 10'd256, 10'd1, 10'd8);
        check("bad2_fail_cnt", fail_cnt, 2);
        check("bad2_alarm", alarm, 0);
        enter4(10'd1, 10'd512, 10'd8, 10'd4);
        check("bad3_alarm", alarm, 1);
        n = 0;
        err_seen = 1'b0;
        unl_seen = 1'b0;
        key_valid = 1'b1;
        key = 10'd0;
        while (alarm && n < 50) begin
            if (key_err) err_seen = 1'b1;
            if (unlocked || digit_cnt != 3'd0) unl_seen = 1'b1;
            n++;
            @(negedge clk);
        end
        key_valid = 1'b0;
        key = 10'd0;
        check("lock_alarm_len", n, 16);
        check("lock_no_key_err", err_seen, 0);
        check("lock_keys_ignored", unl_seen, 0);
        check("lock_fail_cleared", fail_cnt, 0);

        // Clear aborts the partial entry; clear wins over a same-cycle key.
        enter4(10'd256, 10'd256, 10'd1, 10'd8);
        check("clr_pre_fail", fail_cnt, 1);
        press(10'd1);
        press(10'd512);
        check("clr_pre_digit", digit_cnt, 2);
        clear = 1'b1;
        key_valid = 1'b1;
        key = 10'd8;
        @(negedge clk);
        clear = 1'b0;
        key_valid = 1'b0;
        key = 10'd0;
        check("clr_digit", digit_cnt, 0);
        check("clr_fail_kept", fail_cnt, 1);
        enter4(10'd1, 10'd512, 10'd8, 10'd2);
        check("clr_unlocked", unlocked, 1);
        check("clr_fail_reset", fail_cnt, 0);
        count_unlocked(n);
        check("clr_unlock_len", n, 8);

        // Invalid keys pulse key_err, advance digit_cnt and spoil the entry.
        press(10'd1);
        press(10'd36);
        check("inv36_key_err", key_err, 1);
        check("inv36_digit", digit_cnt, 2);
        @(negedge clk);
        check("inv_pulse_end", key_err, 0);
        press(10'd0);
        check("inv0_key_err", key_err, 1);
        check("inv0_digit", digit_cnt, 3);
        press(10'd2);
        check("inv_entry_locked", unlocked, 0);
        check("inv_entry_fail", fail_cnt, 1);
        check("inv_last_ok_no_err", key_err, 0);
        enter4(10'd256, 10'd36, 10'd512, 10'd36);
        check("inv2_key_err", key_err, 1);
        check("inv2_fail", fail_cnt, 2);

        // Asynchronous reset in the middle of a lockout.
        enter4(10'd256, 10'd256, 10'd256, 10'd256);
        check("rl_alarm", alarm, 1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rl_alarm_async", alarm, 0);
        check("rl_fail_async", fail_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        enter4(10'd1, 10'd512, 10'd8, 10'd2);
        check("rl_unlocked", unlocked, 1);
        count_unlocked(n);
        check("rl_unlock_len", n, 8);

`ifdef CODE_PROG_EN
        // Program 4,4,4,4, then abort a second programming attempt.
        enter4(10'd1, 10'd512, 10'd8, 10'd2);
        check("pg_open", unlocked, 1);
        prog = 1'b1;
        @(negedge clk);
        prog = 1'b0;
        check("pg_unlock_drop", unlocked, 0);
        enter4(10'd4, 10'd4, 10'd4, 10'd4);
        check("pg_done_digit", digit_cnt, 0);
        enter4(10'd1, 10'd512, 10'd8, 10'd2);
        check("pg_old_fails", unlocked, 0);
        check("pg_old_fail_cnt", fail_cnt, 1);
        enter4(10'd4, 10'd4, 10'd4, 10'd4);
        check("pg_new_opens", unlocked, 1);
        prog = 1'b1;
        @(negedge clk);
        prog = 1'b0;
        press(10'd1);
        press(10'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("pg_abort_digit", digit_cnt, 0);
        enter4(10'd4, 10'd4, 10'd4, 10'd4);
        check("pg_abort_kept", unlocked, 1);
        count_unlocked(n);
        check("pg_unlock_len", n, 8);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

endmodule
